// File: rtl/mux_arb_pkg.sv
// Shared encodings and constants for the N-to-1 arbitrated mux.
// Optional xfer_count port is enabled by MUX_ARB_XFER_COUNT_EN.
package mux_arb_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int XFER_CNT_W = 16;

endpackage

// File: rtl/mux_nto1_arb_rr_arbiter.sv
// Combinational round-robin search starting after last_grant.
// State lives in the parent; this block only picks a winner.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] last_grant,
  output logic          grant_valid,
  output logic [SW-1:0] grant_index
);

  always_comb begin
    int idx;
    logic [SW-1:0] pos;
    grant_valid = 1'b0;
    grant_index = '0;
    idx = 0;
    pos = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant) + k) % N;
      pos = SW'(idx);
      if (!grant_valid && req[pos]) begin
        grant_valid = 1'b1;
        grant_index = pos;
      end
    end
  end

endmodule

// File: rtl/mux_nto1_arb.sv
// N-to-1 word mux with fixed or round-robin selection and a
// registered output. MUX_ARB_XFER_COUNT_EN adds xfer_count.
module mux_nto1_arb
  import mux_arb_pkg::*;
#(
  parameter int WORD_LENGTH = 32,
  parameter int NUM_INPUTS  = 4,
  parameter int SEL_WIDTH   = $clog2(NUM_INPUTS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mode,
  input  logic [SEL_WIDTH-1:0]        selector,
  input  logic [NUM_INPUTS-1:0]       in_valid,
  input  logic [NUM_INPUTS*WORD_LENGTH-1:0] in_data,
  output logic [NUM_INPUTS-1:0]       in_ready,
  output logic                        out_valid,
  output logic [WORD_LENGTH-1:0]      out_data,
  output logic [SEL_WIDTH-1:0]        out_source,
  input  logic                        out_ready
`ifdef MUX_ARB_XFER_COUNT_EN
  ,
  output logic [XFER_CNT_W-1:0]       xfer_count
`endif
);

  localparam int N  = NUM_INPUTS;
  localparam int SW = SEL_WIDTH;
  localparam int W  = WORD_LENGTH;

  logic [W-1:0]  ch [N];
  logic [SW-1:0] last_grant;
  logic          load_en;
  logic          sel_ok;
  logic          fix_grant;
  logic          rr_valid;
  logic [SW-1:0] rr_index;
  logic          grant;
  logic [SW-1:0] gidx;
  logic          take;

  for (genvar i = 0; i < N; i++) begin : g_split
    assign ch[i] = in_data[i*W +: W];
  end

  // A full-range selector cannot go out of bounds.
  if ((1 << SW) == N) begin : g_sel_full
    assign sel_ok = 1'b1;
  end else begin : g_sel_part
    assign sel_ok = selector < SW'(N);
  end

  rr_arbiter #(
    .N  (N),
    .SW (SW)
  ) u_rr (
    .req         (in_valid),
    .last_grant  (last_grant),
    .grant_valid (rr_valid),
    .grant_index (rr_index)
  );

  assign load_en   = ~out_valid | out_ready;
  assign fix_grant = sel_ok & in_valid[selector];
  assign grant     = (mode == MODE_RR) ? rr_valid : fix_grant;
  assign gidx      = (mode == MODE_RR) ? rr_index : selector;
  assign take      = grant & load_en & ~reset;

  assign in_ready = take
    ? ({{(N-1){1'b0}}, 1'b1} << gidx)
    : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_source <= '0;
      last_grant <= SW'(N-1);
    end else if (take) begin
      out_valid  <= 1'b1;
      out_data   <= ch[gidx];
      out_source <= gidx;
      if (mode == MODE_RR)
        last_grant <= gidx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_ARB_XFER_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      xfer_count <= '0;
    else if (out_valid & out_ready)
      xfer_count <= xfer_count + 1'b1;
  end
`endif

endmodule

// File: doc/mux_nto1_arb.md
Name: mux_nto1_arb

Overview:
- Parametrised N-to-1 word multiplexer with per-channel valid/ready handshakes and a registered output stage.
- Successor to the combinational 2:1/4:1 mux trees in the datapath.
- Supports two selection modes:
  - fixed: an external selector picks the channel, as the existing muxes do.
  - round-robin: the block arbitrates among channels that present valid data.
- Used where several producers share one consumer, e.g. write-back and memory-response merging.

Parameters:
- WORD_LENGTH, 32, data width per channel in bits.
- NUM_INPUTS, 4, number of input channels; legal range 2..16.
- SEL_WIDTH, $clog2(NUM_INPUTS), selector/source width. Derived; never overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = fixed selector, 1 = round-robin arbitration.
- selector  input  SEL_WIDTH  channel to pass in fixed mode.
- in_valid  input  NUM_INPUTS  bit i set: channel i offers a word.
- in_data  input  NUM_INPUTS*WORD_LENGTH  channel i occupies bits [i*WORD_LENGTH +: WORD_LENGTH].
- in_ready  output  NUM_INPUTS  bit i set: channel i's word is consumed this cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  WORD_LENGTH  registered data.
- out_source  output  SEL_WIDTH  channel index that produced out_data.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Clock and reset: single clock domain on clk. Reset is synchronous and active-high, sampled on the rising edge of clk. There are no asynchronous paths.
- Reset values:
  - out_valid = 0, out_data = 0, out_source = 0.
  - Round-robin pointer last_grant = NUM_INPUTS-1, so channel 0 has first priority after reset.
- Reset mid-transfer: the held word is discarded and no in_ready is asserted that cycle.
- Load enable: load_en = ~out_valid | out_ready. This is a one-entry pipeline register that sustains full throughput.
- Grant, fixed mode (mode = 0):
  - Candidate = selector.
  - grant = in_valid[selector] & (selector < NUM_INPUTS).
  - An out-of-range selector grants nothing; no in_ready is asserted and the output drains normally.
- Grant, round-robin mode (mode = 1):
  - Search starts at (last_grant+1) mod NUM_INPUTS and wraps around.
  - The first channel with in_valid set wins.
  - No valid channel means no grant.
- Handshake:
  - in_ready[g] = grant & load_en, one-hot or all zero; purely combinational from inputs and state.
  - in_ready bits never depend on out_valid from the same channel.
- Transfer: when in_ready[g] = 1, at the next edge out_data <= channel g data, out_source <= g, out_valid <= 1.
  - last_grant <= g, in round-robin mode only.
- Drain: if out_ready = 1 and out_valid = 1 with no grant, out_valid <= 0 at the next edge. out_data and out_source hold their last values.
- Stall: when out_valid = 1 and out_ready = 0, out_data, out_source and out_valid stay stable and in_ready = 0.
- Latency: 1 cycle from input handshake to out_valid. Throughput is 1 word/cycle with out_ready held high.
- Simultaneous drain and load: both happen in the same cycle; out_valid stays 1 with the new word.
- Mode switch: takes effect in the same cycle's grant computation. last_grant is not altered by fixed-mode transfers.
- Fairness: in round-robin mode, a continuously valid channel is served at least once every NUM_INPUTS transfers.

Optional Feature:
- Macro MUX_ARB_XFER_COUNT_EN.
- When defined: adds output port xfer_count (16 bits), the count of completed output handshakes (out_valid & out_ready).
  - Reset to 0.
  - Wraps from 16'hFFFF to 0.
  - Updates at the edge following the handshake.
- When undefined: the port and counter are absent; there is no other change.

Decomposition:
- Shared package mux_arb_pkg holds:
  - mode encodings MODE_FIXED = 1'b0, MODE_RR = 1'b1.
  - the counter width constant XFER_CNT_W = 16.
- One natural sub-module, rr_arbiter: inputs request vector and last_grant; outputs grant_valid and grant_index. Purely combinational; the state stays in the parent.

Test Plan:
- Reset, then mode = 0, selector = 2, in_valid = 4'b0100, ch2 = 32'hDEADBEEF, out_ready = 1 → in_ready = 4'b0100. Next cycle out_valid = 1, out_data = 32'hDEADBEEF, out_source = 2.
- mode = 1, in_valid = 4'b1111 held, out_ready = 1 for 8 cycles → out_source sequence 0,1,2,3,0,1,2,3, with one word every cycle.
- mode = 1, in_valid = 4'b1010, out_ready = 0 after the first transfer → out_source = 1 held stable and in_ready = 0. Raise out_ready → next out_source = 3.
- NUM_INPUTS = 3, mode = 0, selector = 3, in_valid = 3'b111 → in_ready = 0 and out_valid stays 0.
- Assert reset while out_valid = 1 and out_ready = 0 → next cycle out_valid = 0, out_data = 0. First round-robin grant after reset goes to channel 0.
- With MUX_ARB_XFER_COUNT_EN defined: run 70000 back-to-back transfers → xfer_count = 70000 mod 65536 = 4464.
